// File: rtl/hyper_ram_responder.sv
// HyperRAM device model answering word-level HyperBus PHY transactions.
// Decodes the 48-bit CA sequence, applies (optionally doubled) access latency,
// serves reads and byte-masked writes from a 16-bit memory, and holds CR0.
module hyper_ram_responder #(
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned LatencyDefault  = 6,
  parameter int unsigned FixedLatDefault = 1,
  parameter int unsigned WrapWords       = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic        tx_valid_i,
  input  logic [15:0] tx_data_i,
  input  logic [1:0]  tx_mask_i,
  input  logic        refresh_i,
  output logic        rwds_lat_o,
  output logic        rx_valid_o,
  output logic [15:0] rx_data_o,
  output logic [15:0] cr0_o
);

  localparam int unsigned          Depth    = 1 << AddrWidth;
  localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(WrapWords - 1);
  localparam logic [15:0]          Cr0Reset = {11'd0, 1'(FixedLatDefault), 4'(LatencyDefault)};

  typedef enum logic [2:0] {
    StIdle,
    StCa,
    StLatency,
    StRead,
    StWrite,
    StRegWrite
  } state_e;

  state_e               state_q, state_d;
  logic                 ca_word2_q, ca_word2_d;  // next CA word expected is word 2
  logic [31:0]          ca_hi_q, ca_hi_d;        // CA words 0 and 1
  logic                 dbl_q, dbl_d;
  logic [3:0]           lat_q, lat_d;            // CR0 latency captured at word 0
  logic [4:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 reg_done_q, reg_done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [15:0]          rx_data_q, rx_data_d;
  logic [15:0]          cr0_q, cr0_d;
  logic [15:0]          mem_q [Depth];
  logic                 mem_we;

  // CA field decode; ca_hi_q stays stable for the whole transaction.
  logic                 ca_read, ca_reg, ca_linear;
  logic [31:0]          ca_addr_full;
  logic [4:0]           lat_cycles;
  logic [AddrWidth-1:0] addr_inc, addr_wrap, addr_next;
  logic [15:0]          rd_word;

  assign ca_read      = ca_hi_q[31];
  assign ca_reg       = ca_hi_q[30];
  assign ca_linear    = ca_hi_q[29];
  assign ca_addr_full = {ca_hi_q[28:0], tx_data_i[2:0]};
  assign lat_cycles   = dbl_q ? {lat_q, 1'b0} : {1'b0, lat_q};

  // Wrapped bursts only advance the low bits inside the wrap group.
  assign addr_inc  = addr_q + AddrWidth'(1);
  assign addr_wrap = (addr_q & ~WrapMask) | (addr_inc & WrapMask);
  assign addr_next = ca_reg ? addr_q : (ca_linear ? addr_inc : addr_wrap);
  assign rd_word   = ca_reg ? cr0_q : mem_q[addr_q];

  // Address bits above the memory depth are discarded (modulo addressing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^ca_addr_full[31:AddrWidth];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; chip-select deassertion aborts from any state.
  always_comb begin
    state_d = state_q;
    if (cs_ni) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx_valid_i) state_d = StCa;
        end
        StCa: begin
          if (tx_valid_i && ca_word2_q) begin
            state_d = (!ca_read && ca_reg) ? StRegWrite : StLatency;
          end
        end
        StLatency: begin
          if (cnt_q == '0) state_d = ca_read ? StRead : StWrite;
        end
        StRead, StWrite, StRegWrite: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state: CA capture, latency count, data phase, CR0 load.
  always_comb begin
    ca_word2_d = ca_word2_q;
    ca_hi_d    = ca_hi_q;
    dbl_d      = dbl_q;
    lat_d      = lat_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    reg_done_d = reg_done_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cr0_d      = cr0_q;
    mem_we     = 1'b0;
    if (!cs_ni) begin
      case (state_q)
        StIdle: begin
          if (tx_valid_i) begin
            ca_hi_d[31:16] = tx_data_i;
            ca_word2_d     = 1'b0;
            dbl_d          = cr0_q[4] | refresh_i;
            lat_d          = cr0_q[3:0];
            reg_done_d     = 1'b0;
          end
        end
        StCa: begin
          if (tx_valid_i) begin
            if (!ca_word2_q) begin
              ca_hi_d[15:0] = tx_data_i;
              ca_word2_d    = 1'b1;
            end else begin
              addr_d = ca_addr_full[AddrWidth-1:0];
              // Counter runs L cycles; a zero latency field still costs one cycle.
              cnt_d  = (lat_cycles == '0) ? '0 : lat_cycles - 5'd1;
            end
          end
        end
        StLatency: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 5'd1;
          end else if (ca_read) begin
            // Prefetch the first word so it is valid in the first Read cycle.
            rx_data_d  = rd_word;
            rx_valid_d = 1'b1;
            addr_d     = addr_next;
          end
        end
        StRead: begin
          rx_data_d  = rd_word;
          rx_valid_d = 1'b1;
          addr_d     = addr_next;
        end
        StWrite: begin
          if (tx_valid_i) begin
            mem_we = 1'b1;
            addr_d = addr_next;
          end
        end
        StRegWrite: begin
          if (tx_valid_i && !reg_done_q) begin
            cr0_d      = tx_data_i;
            reg_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ca_word2_q <= 1'b0;
      ca_hi_q    <= '0;
      dbl_q      <= 1'b0;
      lat_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      reg_done_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cr0_q      <= Cr0Reset;
    end else begin
      ca_word2_q <= ca_word2_d;
      ca_hi_q    <= ca_hi_d;
      dbl_q      <= dbl_d;
      lat_q      <= lat_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      reg_done_q <= reg_done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cr0_q      <= cr0_d;
    end
  end

  // Memory array with per-byte write enables; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (!tx_mask_i[0]) mem_q[addr_q][7:0]  <= tx_data_i[7:0];
      if (!tx_mask_i[1]) mem_q[addr_q][15:8] <= tx_data_i[15:8];
    end
  end

  // Outputs; both strobes drop in the cycle chip select is released.
  always_comb begin
    rwds_lat_o = (state_q == StCa) & dbl_q & ~cs_ni;
    rx_valid_o = rx_valid_q & ~cs_ni;
    rx_data_o  = rx_data_q;
    cr0_o      = cr0_q;
  end

endmodule

// File: tb/tb_hyper_ram_responder.sv
// Self-checking bench for hyper_ram_responder: a transaction-level model
// schedules the expected outputs per cycle; one process compares them.
module tb_hyper_ram_responder;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs_n = 1'b1;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic [1:0]  tx_mask = '0;
  logic        refresh = 1'b0;
  logic        rwds_lat, rx_valid;
  logic [15:0] rx_data, cr0;

  hyper_ram_responder #(
    .AddrWidth      (10),
    .LatencyDefault (6),
    .FixedLatDefault(1),
    .WrapWords      (16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .cs_ni     (cs_n),
    .tx_valid_i(tx_valid),
    .tx_data_i (tx_data),
    .tx_mask_i (tx_mask),
    .refresh_i (refresh),
    .rwds_lat_o(rwds_lat),
    .rx_valid_o(rx_valid),
    .rx_data_o (rx_data),
    .cr0_o     (cr0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [15:0] mcr0 = 16'h0016;
  logic [15:0] mmem [Depth];
  logic [1:0]  mknown [Depth];

  // Expected outputs for the current cycle.
  logic        exp_rwds = 1'b0;
  logic        exp_rxv = 1'b0;
  logic [15:0] exp_rxd = '0;
  logic        exp_known = 1'b0;
  logic [15:0] exp_cr0 = 16'h0016;
  bit          chk_en = 1'b0;

  logic [15:0] rxq[$];
  logic [17:0] wq[$];  // {mask, data} for upcoming write words
  int          first_rx = -1;
  int          w2_cyc = 0;
  logic        prev_rxv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic r1();
    return 1'($urandom);
  endfunction
  function automatic logic [1:0] r2();
    return 2'($urandom);
  endfunction
  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  function automatic int nxt(input int a, input bit lin, input bit rs);
    if (rs) return a;
    if (lin) return (a + 1) % Depth;
    return (a / 16) * 16 + ((a + 1) % 16);
  endfunction

  function automatic logic [15:0] rxq_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 16'hxxxx;
  endfunction

  // Compare process: DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rwds_lat", 32'(rwds_lat), 32'(exp_rwds));
      check("rx_valid", 32'(rx_valid), 32'(exp_rxv));
      if (exp_rxv && exp_known) check("rx_data", 32'(rx_data), 32'(exp_rxd));
      check("cr0", 32'(cr0), 32'(exp_cr0));
      if (rx_valid === 1'b1) begin
        rxq.push_back(rx_data);
        if (prev_rxv !== 1'b1 && first_rx < 0) first_rx = cyc;
      end
      prev_rxv = rx_valid;
    end
  end

  // One bus cycle: drive inputs and state what the outputs must be.
  task automatic step(input logic cs, input logic v, input logic [15:0] d, input logic [1:0] m,
                      input logic rf, input logic rw, input logic rv, input logic [15:0] rdv,
                      input logic rk);
    @(posedge clk);
    #1;
    cs_n      = cs;
    tx_valid  = v;
    tx_data   = d;
    tx_mask   = m;
    refresh   = rf;
    exp_rwds  = rw;
    exp_rxv   = rv;
    exp_rxd   = rdv;
    exp_known = rk;
    exp_cr0   = mcr0;
  endtask

  task automatic idle_step();
    step(1'b1, r1(), r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic quiet_step();
    step(1'b0, r1(), r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Idle gap, then the three CA words with random stalls between them.
  task automatic send_ca(input bit rd, input bit rs, input bit lin, input int addr,
                         input bit rf, output bit dbl);
    logic [47:0] ca;
    logic [28:0] up;
    up      = 29'($urandom);
    up[6:0] = 7'(addr >> 3);
    ca      = {rd, rs, lin, up, 13'($urandom), 3'(addr)};
    dbl     = mcr0[4] | rf;
    idle_step();
    step(1'b0, 1'b1, ca[47:32], r2(), rf, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, r16(), r2(), r1(), dbl, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, (k == 1) ? ca[31:16] : ca[15:0], r2(), r1(), dbl, 1'b0, '0, 1'b0);
    end
    w2_cyc = cyc;
  endtask

  task automatic do_regwrite(input logic [15:0] val, input bit rf);
    bit dbl;
    send_ca(1'b0, 1'b1, r1(), int'($urandom_range(0, Depth - 1)), rf, dbl);
    repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, val, r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
    mcr0 = val;
    step(1'b0, 1'b1, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset_mid();
    #2;
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    tx_valid = 1'b0;
    mcr0     = 16'h0016;
    exp_rwds = 1'b0;
    exp_rxv  = 1'b0;
    exp_cr0  = mcr0;
    #1;
    check("arst_rx_valid", 32'(rx_valid), 32'(0));
    check("arst_rx_data", 32'(rx_data), 32'(0));
    check("arst_cr0", 32'(cr0), 32'h0016);
    for (int i = 0; i < Depth; i++) mknown[i] = 2'b00;
    repeat (2) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Memory/register access; the closing cycle presents a word with cs high.
  task automatic do_access(input bit rd, input bit rs, input bit lin, input int addr, input int n,
                           input bit rf, input int abort_at);
    bit          dbl;
    int          lat;
    int          a;
    int          j;
    logic [17:0] wd;
    send_ca(rd, rs, lin, addr, rf, dbl);
    lat = int'(mcr0[3:0]) * (dbl ? 2 : 1);
    repeat (lat) quiet_step();  // words offered during latency are dropped
    a = addr % Depth;
    j = 0;
    while (j < n) begin
      if (rd) begin
        step(1'b0, r1(), r16(), r2(), r1(), 1'b0, 1'b1, rs ? mcr0 : mmem[a],
             rs || (mknown[a] == 2'b11));
        if (j == abort_at) begin
          do_reset_mid();
          return;
        end
        a = nxt(a, lin, rs);
        j++;
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b0, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
      end else begin
        wd = (wq.size() > 0) ? wq.pop_front() : 18'($urandom);
        step(1'b0, 1'b1, wd[15:0], wd[17:16], r1(), 1'b0, 1'b0, '0, 1'b0);
        if (!wd[16]) begin mmem[a][7:0] = wd[7:0]; mknown[a][0] = 1'b1; end
        if (!wd[17]) begin mmem[a][15:8] = wd[15:8]; mknown[a][1] = 1'b1; end
        a = nxt(a, lin, rs);
        j++;
      end
    end
    step(1'b1, 1'b1, r16(), r2(), r1(), 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mknown[i] = 2'b00;
    #2;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_cr0", 32'(cr0), 32'h0016);
    repeat (3) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    repeat (2) idle_step();

    // CR0 write takes effect the cycle after the data word, no latency.
    do_regwrite(16'h0013, 1'b0);
    check("cr0_written", 32'(cr0), 32'h0013);

    // Linear write then read-back with 2 x 3 latency.
    wq = '{{2'b00, 16'h1111}, {2'b00, 16'h2222}, {2'b00, 16'h3333}};
    do_access(1'b0, 1'b0, 1'b1, 'h010, 3, 1'b0, -1);
    rxq.delete();
    first_rx = -1;
    do_access(1'b1, 1'b0, 1'b1, 'h010, 3, 1'b0, -1);
    check("lat_fixed_dbl", 32'(first_rx - w2_cyc), 32'd7);
    check("rd_word0", 32'(rxq_at(0)), 32'h1111);
    check("rd_word1", 32'(rxq_at(1)), 32'h2222);
    check("rd_word2", 32'(rxq_at(2)), 32'h3333);

    // Single latency, then doubled by refresh.
    do_regwrite(16'h0003, 1'b0);
    first_rx = -1;
    do_access(1'b1, 1'b0, 1'b1, 'h010, 2, 1'b0, -1);
    check("lat_single", 32'(first_rx - w2_cyc), 32'd4);
    first_rx = -1;
    do_access(1'b1, 1'b0, 1'b1, 'h010, 2, 1'b1, -1);
    check("lat_refresh", 32'(first_rx - w2_cyc), 32'd7);

    // Upper byte masked.
    wq = '{{2'b00, 16'h1234}};
    do_access(1'b0, 1'b0, 1'b1, 'h020, 1, 1'b0, -1);
    wq = '{{2'b10, 16'hABCD}};
    do_access(1'b0, 1'b0, 1'b1, 'h020, 1, 1'b0, -1);
    rxq.delete();
    do_access(1'b1, 1'b0, 1'b1, 'h020, 1, 1'b0, -1);
    check("masked_write", 32'(rxq_at(0)), 32'h12CD);

    // Wrapped read across the 16-word group boundary.
    for (int i = 0; i < 16; i++) wq.push_back({2'b00, 16'(16'h5010 + i)});
    do_access(1'b0, 1'b0, 1'b1, 'h010, 16, 1'b0, -1);
    rxq.delete();
    do_access(1'b1, 1'b0, 1'b0, 'h01E, 4, 1'b0, -1);
    check("wrap0", 32'(rxq_at(0)), 32'h501E);
    check("wrap1", 32'(rxq_at(1)), 32'h501F);
    check("wrap2", 32'(rxq_at(2)), 32'h5010);
    check("wrap3", 32'(rxq_at(3)), 32'h5011);

    // Chip select released before the third write word.
    wq = '{{2'b00, 16'hAAA0}, {2'b00, 16'hAAA1}, {2'b00, 16'hAAA2}};
    do_access(1'b0, 1'b0, 1'b1, 'h040, 3, 1'b0, -1);
    wq = '{{2'b00, 16'hBBB0}, {2'b00, 16'hBBB1}};
    do_access(1'b0, 1'b0, 1'b1, 'h040, 2, 1'b0, -1);
    rxq.delete();
    do_access(1'b1, 1'b0, 1'b1, 'h040, 3, 1'b0, -1);
    check("cut0", 32'(rxq_at(0)), 32'hBBB0);
    check("cut1", 32'(rxq_at(1)), 32'hBBB1);
    check("cut2_kept", 32'(rxq_at(2)), 32'hAAA2);

    // Register-space read returns CR0 every cycle.
    rxq.delete();
    do_access(1'b1, 1'b1, 1'b1, int'($urandom_range(0, Depth - 1)), 3, 1'b0, -1);
    check("reg_read", 32'(rxq_at(2)), 32'h0003);

    // Randomised traffic against the model.
    for (int t = 0; t < 60; t++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        do_regwrite({11'($urandom), r1(), 4'($urandom_range(1, 4))}, r1());
      end else if (sel == 1) begin
        do_access(1'b1, 1'b1, r1(), int'($urandom_range(0, Depth - 1)),
                  int'($urandom_range(1, 3)), r1(), -1);
      end else begin
        do_access(r1(), 1'b0, r1(), int'($urandom_range(0, 127)), int'($urandom_range(1, 6)),
                  r1(), -1);
      end
    end

    // Asynchronous reset in the middle of a read burst.
    do_regwrite(16'h0002, 1'b0);
    do_access(1'b1, 1'b0, 1'b1, 'h010, 5, 1'b0, 2);
    wq = '{{2'b00, 16'hC0DE}, {2'b00, 16'hF00D}};
    do_access(1'b0, 1'b0, 1'b1, 'h030, 2, 1'b0, -1);
    rxq.delete();
    first_rx = -1;
    do_access(1'b1, 1'b0, 1'b1, 'h030, 2, 1'b0, -1);
    check("lat_after_rst", 32'(first_rx - w2_cyc), 32'd13);
    check("post_rst_rd1", 32'(rxq_at(1)), 32'hF00D);

    repeat (2) idle_step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
